// File: rtl/score_display_pkg.sv
// Shared constants and types for the BCD score display: active-low segment
// patterns ({g,f,e,d,c,b,a}) and the converter FSM state encoding.
package score_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD digit to active-low 7-segment decoder; any nibble above 9
// produces a blank display.
module bcd_seg_decode
    import score_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_bcd_display.sv
// Binary score to NUM_DIGITS BCD digits and 7-segment patterns, using an
// iterative shift-and-add-3 converter. Build option: SCORE_LEADING_ZERO_BLANK_EN.
module score_bcd_display
    import score_display_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_DIGITS = 3
)
(
    input  logic                      Clck,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         Data_In,
    input  logic                      load,
    output logic                      ready,
    output logic                      done,
    output logic                      overflow,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [7*NUM_DIGITS-1:0]   hex_out
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int HEX_W = 7 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);
    localparam logic [31:0]      OVF_LIMIT = 32'(10 ** NUM_DIGITS);

    function automatic logic [HEX_W-1:0] hex_reset_value();
        logic [HEX_W-1:0] v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            v[7*i +: 7] = SEG_DIGIT[0];
`ifdef SCORE_LEADING_ZERO_BLANK_EN
            if (i != 0) v[7*i +: 7] = SEG_BLANK;
`endif
        end
        return v;
    endfunction

    localparam logic [HEX_W-1:0] HEX_RST = hex_reset_value();

    // Double-dabble correction: any nibble that would reach 10+ after the
    // next shift gets 3 added first.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    state_t            state, state_nxt;
    logic [DATA_W-1:0] bin_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;

    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_step;
    logic [6:0]        seg_dig [NUM_DIGITS];
    logic [HEX_W-1:0]  hex_next;
    logic              last_iter;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    logic              lz;
`endif

    assign bcd_adj   = add3(bcd_q);
    assign bcd_step  = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
    assign last_iter = (state == CONVERT) && (cnt_q == LAST_ITER);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        bcd_seg_decode u_dec (
            .bcd (bcd_step[4*g +: 4]),
            .seg (seg_dig[g])
        );
    end

    always_comb begin
        hex_next = '0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        lz = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz = lz & (bcd_step[4*i +: 4] == 4'd0);
            if (ovf_q)
                hex_next[7*i +: 7] = SEG_DASH;
            else if (lz && (i != 0))
                hex_next[7*i +: 7] = SEG_BLANK;
            else
                hex_next[7*i +: 7] = seg_dig[i];
        end
`else
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_next[7*i +: 7] = ovf_q ? SEG_DASH : seg_dig[i];
        end
`endif
    end

    always_ff @(posedge Clck or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = CONVERT;
            CONVERT: if (cnt_q == LAST_ITER) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        done  = (state == COMMIT);
    end

    // Output registers load on the final iteration edge so they are already
    // valid during the COMMIT cycle, aligned with the done pulse.
    always_ff @(posedge Clck or posedge reset) begin
        if (reset) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            bcd_out  <= '0;
            hex_out  <= HEX_RST;
            overflow <= 1'b0;
        end else begin
            if ((state == IDLE) && load) begin
                bin_q <= Data_In;
                bcd_q <= '0;
                cnt_q <= '0;
                ovf_q <= (32'(Data_In) >= OVF_LIMIT);
            end
            if (state == CONVERT) begin
                bin_q <= bin_q << 1;
                bcd_q <= bcd_step;
                cnt_q <= cnt_q + 1'b1;
            end
            if (last_iter) begin
                bcd_out  <= bcd_step;
                hex_out  <= hex_next;
                overflow <= ovf_q;
            end
        end
    end

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed bench for score_bcd_display with a 2-digit and a 3-digit instance
// sharing clock and reset; expectations follow SCORE_LEADING_ZERO_BLANK_EN.
module tb_score_bcd_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b0111111;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    localparam logic [13:0] HEX2_RST = {SB, S0};
    localparam logic [20:0] HEX3_RST = {SB, SB, S0};
    localparam logic [20:0] HEX3_ZERO = {SB, SB, S0};
    localparam logic [20:0] HEX3_SEVEN = {SB, SB, S7};
    localparam logic [20:0] HEX3_FIVE = {SB, SB, S5};
`else
    localparam logic [13:0] HEX2_RST = {S0, S0};
    localparam logic [20:0] HEX3_RST = {S0, S0, S0};
    localparam logic [20:0] HEX3_ZERO = {S0, S0, S0};
    localparam logic [20:0] HEX3_SEVEN = {S0, S0, S7};
    localparam logic [20:0] HEX3_FIVE = {S0, S0, S5};
`endif

    logic        Clck;
    logic        reset;
    logic [7:0]  din2, din3;
    logic        load2, load3;
    logic        ready2, ready3, done2, done3, ovf2, ovf3;
    logic [7:0]  bcd2;
    logic [11:0] bcd3;
    logic [13:0] hex2;
    logic [20:0] hex3;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int ndone;
    int rdy_at;

    score_bcd_display #(.DATA_W(8), .NUM_DIGITS(2)) u_dut2 (
        .Clck     (Clck),
        .reset    (reset),
        .Data_In  (din2),
        .load     (load2),
        .ready    (ready2),
        .done     (done2),
        .overflow (ovf2),
        .bcd_out  (bcd2),
        .hex_out  (hex2)
    );

    score_bcd_display #(.DATA_W(8), .NUM_DIGITS(3)) u_dut3 (
        .Clck     (Clck),
        .reset    (reset),
        .Data_In  (din3),
        .load     (load3),
        .ready    (ready3),
        .done     (done3),
        .overflow (ovf3),
        .bcd_out  (bcd3),
        .hex_out  (hex3)
    );

    initial begin
        Clck = 1'b0;
        forever #5 Clck = ~Clck;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept edge sits between the two negedges; returns on the first negedge after it.
    task automatic start(input int sel, input logic [7:0] v);
        @(negedge Clck);
        chk("ready_before_load", (sel == 2) ? ready2 : ready3, 1);
        if (sel == 2) begin din2 = v; load2 = 1'b1; end
        else          begin din3 = v; load3 = 1'b1; end
        @(negedge Clck);
        load2 = 1'b0;
        load3 = 1'b0;
        chk("ready_busy", (sel == 2) ? ready2 : ready3, 0);
    endtask

    task automatic wait_done(input int sel, output int l);
        l = 0;
        for (int k = 2; k <= 30; k++) begin
            @(negedge Clck);
            if (((sel == 2) ? done2 : done3) === 1'b1) begin
                l = k;
                break;
            end
        end
        chk("done_latency", l, 9);
    endtask

    task automatic after_done(input int sel);
        @(negedge Clck);
        chk("done_one_cycle", (sel == 2) ? done2 : done3, 0);
        chk("ready_return", (sel == 2) ? ready2 : ready3, 1);
    endtask

    initial begin
        reset = 1'b0;
        load2 = 1'b0; load3 = 1'b0;
        din2  = '0;   din3  = '0;
        #3 reset = 1'b1;
        @(negedge Clck);
        @(negedge Clck);
        chk("rst_ready2", ready2, 1);
        chk("rst_done2", done2, 0);
        chk("rst_ovf2", ovf2, 0);
        chk("rst_bcd2", bcd2, 0);
        chk("rst_hex2", hex2, HEX2_RST);
        chk("rst_ready3", ready3, 1);
        chk("rst_done3", done3, 0);
        chk("rst_hex3", hex3, HEX3_RST);
        reset = 1'b0;

        // 42 on two digits
        start(2, 8'd42);
        wait_done(2, lat);
        chk("t1_bcd", bcd2, 8'h42);
        chk("t1_hex", hex2, {S4, S2});
        chk("t1_ovf", ovf2, 0);
        after_done(2);
        repeat (3) @(negedge Clck);
        chk("t1_hold_bcd", bcd2, 8'h42);

        // 255 then 0 on three digits
        start(3, 8'd255);
        wait_done(3, lat);
        chk("t2_bcd", bcd3, 12'h255);
        chk("t2_hex", hex3, {S2, S5, S5});
        after_done(3);
        start(3, 8'd0);
        wait_done(3, lat);
        chk("t2_zero_bcd", bcd3, 12'h000);
        chk("t2_zero_hex", hex3, HEX3_ZERO);
        after_done(3);

        // overflow on two digits, then recovery
        start(2, 8'd100);
        wait_done(2, lat);
        chk("t3_ovf", ovf2, 1);
        chk("t3_hex", hex2, {SD, SD});
        chk("t3_bcd", bcd2, 8'h00);
        after_done(2);
        start(2, 8'd99);
        wait_done(2, lat);
        chk("t3b_ovf", ovf2, 0);
        chk("t3b_bcd", bcd2, 8'h99);
        chk("t3b_hex", hex2, {S9, S9});
        after_done(2);

        // 17 then load held high with 88 while busy
        @(negedge Clck);
        chk("t4_ready", ready2, 1);
        din2 = 8'd17; load2 = 1'b1;
        @(negedge Clck);
        din2 = 8'd88;
        chk("t4_busy", ready2, 0);
        ndone = 0; rdy_at = 0;
        for (int k = 1; k <= 30; k++) begin
            if (done2 === 1'b1) ndone++;
            if (ready2 === 1'b1) begin
                load2 = 1'b0;
                rdy_at = k;
                break;
            end
            @(negedge Clck);
        end
        load2 = 1'b0;
        repeat (12) begin
            @(negedge Clck);
            if (done2 === 1'b1) ndone++;
        end
        chk("t4_ready_at", rdy_at, 10);
        chk("t4_done_count", ndone, 1);
        chk("t4_bcd", bcd2, 8'h17);
        chk("t4_hex", hex2, {S1, S7});

        // 7 on three digits
        start(3, 8'd7);
        wait_done(3, lat);
        chk("t6_bcd", bcd3, 12'h007);
        chk("t6_hex", hex3, HEX3_SEVEN);
        after_done(3);

        // reset mid-conversion
        start(3, 8'd200);
        @(negedge Clck);
        @(negedge Clck);
        reset = 1'b1;
        #1;
        chk("t5_rst_ready", ready3, 1);
        chk("t5_rst_done", done3, 0);
        chk("t5_rst_bcd", bcd3, 0);
        chk("t5_rst_hex", hex3, HEX3_RST);
        chk("t5_rst_ovf", ovf3, 0);
        chk("t5_rst_hex2", hex2, HEX2_RST);
        @(negedge Clck);
        reset = 1'b0;
        ndone = 0;
        repeat (15) begin
            @(negedge Clck);
            if (done3 === 1'b1) ndone++;
        end
        chk("t5_no_done", ndone, 0);
        chk("t5_bcd_held", bcd3, 0);
        start(3, 8'd5);
        wait_done(3, lat);
        chk("t5b_bcd", bcd3, 12'h005);
        chk("t5b_hex", hex3, HEX3_FIVE);
        after_done(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
